int_seq: RTL
============

Name: int_seq

Overview:
- Interrupt sequencer for the Gumnut core; the restore side of the interrupt register that captures ipc/intc/intz.
- Accepts a level interrupt request at instruction boundaries.
- Drives the interrupt register write-enable on entry, and redirects the PC to the handler vector.
- On reti, reads the saved PC and flags back into the PC and ALU flag registers.
- Also owns the global interrupt-enable flag (enai/disi).

Parameters:
- PC_W, 12, program counter width.
- VECTOR, 12'h001, handler entry address loaded on interrupt entry.

Ports:
- clkg  in  1  gated clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- int_req  in  1  level interrupt request from the peripheral.
- instr_done  in  1  current instruction completes this cycle; qualifies the op_* inputs and pc_i.
- op_enai  in  1  decoded enai; valid only with instr_done.
- op_disi  in  1  decoded disi; valid only with instr_done.
- op_reti  in  1  decoded reti; valid only with instr_done.
- pc_i  in  PC_W  address of the next instruction; held stable while stall=1.
- ipc_i  in  PC_W  saved PC from the interrupt register.
- intc_i  in  1  saved carry from the interrupt register.
- intz_i  in  1  saved zero flag from the interrupt register.
- save_we  out  1  write-enable to the interrupt register (captures pc_i, carry, zero).
- pc_load  out  1  force the PC to pc_load_val at the next edge.
- pc_load_val  out  PC_W  PC override value.
- flag_load  out  1  force the ALU carry/zero flags at the next edge.
- c_o  out  1  carry restore value.
- z_o  out  1  zero restore value.
- int_ack  out  1  one-cycle pulse when an interrupt is accepted.
- int_en  out  1  global interrupt enable.
- in_isr  out  1  handler is active.
- stall  out  1  core must hold PC/fetch.
- bad_reti  out  1  one-cycle pulse on reti outside the handler.

Behaviour:
- Reset: state=IDLE, int_en=0, all other outputs 0. Reset mid-sequence (SAVE/VECTOR/RESTORE) aborts to IDLE with no partial load remaining asserted.
- All outputs except int_en, in_isr and bad_reti are Moore decodes of state. int_en and bad_reti are registered.
- IDLE:
  - Accept condition: instr_done & int_req & int_en & !op_disi. If true, next state is SAVE.
  - Else if instr_done & op_disi: int_en<=0.
  - Else if instr_done & op_enai: int_en<=1. The new enable is sampled from the next boundary onward (one-instruction shadow; a pending request is not taken at the enai boundary itself).
  - instr_done & op_reti: bad_reti pulses next cycle, no other effect.
- SAVE (1 cycle): save_we=1, int_ack=1, stall=1, int_en<=0. Next state VECTOR.
- VECTOR (1 cycle): pc_load=1, pc_load_val=VECTOR, stall=1. Next state ISR.
- ISR:
  - in_isr=1, stall=0, no nesting: int_req is ignored.
  - enai/disi are ignored (int_en stays 0).
  - instr_done & op_reti: next state RESTORE.
- RESTORE (1 cycle): pc_load=1, pc_load_val=ipc_i, flag_load=1, c_o=intc_i, z_o=intz_i, stall=1, int_en<=1. Next state IDLE.
- Latency:
  - Accepting boundary to handler fetch: 2 cycles (SAVE, VECTOR).
  - reti boundary to resumed fetch at saved PC: 1 cycle.
- Simultaneous events:
  - disi and an eligible request at the same boundary: disi wins, no entry.
  - Request deasserted during SAVE/VECTOR: entry still completes.
  - Request still high at the RESTORE→IDLE transition: it is taken at the next IDLE boundary, so one instruction executes between handlers.
- Width: pc_load_val is exactly PC_W bits, and VECTOR is truncated to PC_W. PC values wrap naturally; no arithmetic is performed here.

Decomposition:
- Package int_seq_pkg holds:
  - the state enum (IDLE, SAVE, VECTOR, ISR, RESTORE), 3 bits;
  - the PC_W default;
  - the VECTOR default constant.
- Single module with no sub-module. The interrupt register stays a separate instance driven by save_we.

Test Plan:
- Reset: rst=1 mid-VECTOR → on release, all outputs 0, int_en=0, state IDLE.
- Basic entry/return:
  - Stimulus: enai at boundary; next boundary int_req=1 with pc_i=12'h0A4.
  - Entry: save_we and int_ack each pulse 1 cycle; the next cycle gives pc_load=1 with pc_load_val=12'h001; int_en=0, in_isr=1.
  - Return stimulus: reti with ipc_i=12'h0A4, intc_i=1, intz_i=0.
  - Return: pc_load_val=12'h0A4, flag_load=1, c_o=1, z_o=0, int_en=1.
- Enable shadow: int_req held high, enai at boundary N → no entry at N; entry (SAVE) at boundary N+1.
- disi priority: int_en=1, int_req=1, disi at same boundary → no save_we; int_en=0 afterwards.
- No nesting: int_req toggled during ISR → no additional save_we until RESTORE completes. With int_req still high at RESTORE, a second entry occurs exactly at the next instr_done after IDLE.
- Spurious reti: reti in IDLE → bad_reti=1 for 1 cycle, no pc_load or flag_load.

Source files
------------

// File: rtl/int_seq_pkg.sv
// Shared types and defaults for the Gumnut interrupt sequencer.
package int_seq_pkg;

    localparam int          PC_W_DEF   = 12;
    localparam logic [11:0] VECTOR_DEF = 12'h001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_ISR     = 3'd3,
        ST_RESTORE = 3'd4
    } state_e;

endpackage

// File: rtl/int_seq_if.sv
// Core / interrupt-register side signals of the interrupt sequencer.
interface int_seq_if #(parameter int PC_W = int_seq_pkg::PC_W_DEF);

    logic            int_req;
    logic            instr_done;
    logic            op_enai;
    logic            op_disi;
    logic            op_reti;
    logic [PC_W-1:0] pc_i;
    logic [PC_W-1:0] ipc_i;
    logic            intc_i;
    logic            intz_i;

    logic            save_we;
    logic            pc_load;
    logic [PC_W-1:0] pc_load_val;
    logic            flag_load;
    logic            c_o;
    logic            z_o;
    logic            int_ack;
    logic            int_en;
    logic            in_isr;
    logic            stall;
    logic            bad_reti;

    modport master (
        output int_req, instr_done, op_enai, op_disi, op_reti, pc_i, ipc_i, intc_i, intz_i,
        input  save_we, pc_load, pc_load_val, flag_load, c_o, z_o, int_ack, int_en,
               in_isr, stall, bad_reti
    );

    modport slave (
        input  int_req, instr_done, op_enai, op_disi, op_reti, pc_i, ipc_i, intc_i, intz_i,
        output save_we, pc_load, pc_load_val, flag_load, c_o, z_o, int_ack, int_en,
               in_isr, stall, bad_reti
    );

endinterface

// File: rtl/int_seq.sv
// Interrupt entry/return sequencer: saves context, vectors to the handler,
// restores PC and flags on reti, and owns the global interrupt enable.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | normal execution, request sampled at instruction boundaries
// ST_SAVE    | interrupt register captures next PC and flags, ack pulse
// ST_VECTOR  | PC forced to the handler vector
// ST_ISR     | handler running, no nesting, enai/disi ignored
// ST_RESTORE | PC and flags reloaded from the interrupt register
module int_seq
    import int_seq_pkg::*;
#(
    parameter int              PC_W   = PC_W_DEF,
    parameter logic [PC_W-1:0] VECTOR = PC_W'(VECTOR_DEF)
) (
    input  logic      clkg,
    input  logic      rst,
    int_seq_if.slave  bus
);

    state_e state_q, state_d;
    logic   int_en_q, int_en_d;
    logic   bad_reti_q, bad_reti_d;
    logic   in_isr_q, in_isr_d;

    logic            save_we, pc_load, flag_load, c_o, z_o, int_ack, stall;
    logic [PC_W-1:0] pc_load_val;
    logic            accept;

    always_ff @(posedge clkg or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            int_en_q   <= 1'b0;
            bad_reti_q <= 1'b0;
            in_isr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            int_en_q   <= int_en_d;
            bad_reti_q <= bad_reti_d;
            in_isr_q   <= in_isr_d;
        end
    end

    // disi at the same boundary blocks entry; enai only takes effect from the next boundary
    assign accept = bus.instr_done & bus.int_req & int_en_q & ~bus.op_disi;

    always_comb begin
        state_d     = state_q;
        int_en_d    = int_en_q;
        bad_reti_d  = 1'b0;
        save_we     = 1'b0;
        int_ack     = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        flag_load   = 1'b0;
        c_o         = 1'b0;
        z_o         = 1'b0;
        stall       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SAVE;
                end else if (bus.instr_done & bus.op_disi) begin
                    int_en_d = 1'b0;
                end else if (bus.instr_done & bus.op_enai) begin
                    int_en_d = 1'b1;
                end
                if (bus.instr_done & bus.op_reti) begin
                    bad_reti_d = 1'b1;
                end
            end
            ST_SAVE: begin
                save_we  = 1'b1;
                int_ack  = 1'b1;
                stall    = 1'b1;
                int_en_d = 1'b0;
                state_d  = ST_VECTOR;
            end
            ST_VECTOR: begin
                pc_load     = 1'b1;
                pc_load_val = VECTOR;
                stall       = 1'b1;
                state_d     = ST_ISR;
            end
            ST_ISR: begin
                if (bus.instr_done & bus.op_reti) begin
                    state_d = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                pc_load     = 1'b1;
                pc_load_val = bus.ipc_i;
                flag_load   = 1'b1;
                c_o         = bus.intc_i;
                z_o         = bus.intz_i;
                stall       = 1'b1;
                int_en_d    = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                int_en_d = 1'b0;
            end
        endcase

        in_isr_d = (state_d == ST_ISR);
    end

    assign bus.save_we     = save_we;
    assign bus.int_ack     = int_ack;
    assign bus.pc_load     = pc_load;
    assign bus.pc_load_val = pc_load_val;
    assign bus.flag_load   = flag_load;
    assign bus.c_o         = c_o;
    assign bus.z_o         = z_o;
    assign bus.stall       = stall;
    assign bus.int_en      = int_en_q;
    assign bus.in_isr      = in_isr_q;
    assign bus.bad_reti    = bad_reti_q;

endmodule
